mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Registered data-memory stage for the multithreaded integer pipeline, sitting between execute and write-back. Each thread has a private data memory of 2^DATA_MEM_ADDR_BITS words. The stage performs byte/half/word/full-width loads and stores with byte-lane write enables, sign or zero extension, and misalignment detection. It has a fixed one-cycle latency and a valid-qualified output register.

## Interface
- DATA_WIDTH, 64: datapath width in bits; power of two, at least 16.
- IMMEDIATE_WIDTH, 16: byte-address field width; at least DATA_MEM_ADDR_BITS+BYTE_BITS.
- REG_INDEX_BITS, 5: destination register index width.
- THREAD_INDEX_BITS, 3: thread index width.
- DATA_MEM_ADDR_BITS, 8: log2 of words per thread.
- Derived: BYTE_BITS = log2(DATA_WIDTH/8); MAX_SIZE = BYTE_BITS.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present this cycle
- in_increment_flag  in  1  ALU result needs write-back
- in_load_flag  in  1  load request
- in_store_flag  in  1  store request
- in_size  in  2  access size is 2^in_size bytes; values above MAX_SIZE clamp to MAX_SIZE
- in_signed_flag  in  1  sign-extend load result when set, zero-extend otherwise
- in_immediate  in  IMMEDIATE_WIDTH  byte address
- in_thread_index  in  THREAD_INDEX_BITS  issuing thread
- in_reg_index  in  REG_INDEX_BITS  destination register
- in_data  in  DATA_WIDTH  store data, or ALU result for pass-through
- out_valid  out  1  registered result valid
- out_write_back_flag  out  1  write out_data to the register file
- out_reg_index  out  REG_INDEX_BITS  registered in_reg_index
- out_thread_index  out  THREAD_INDEX_BITS  registered in_thread_index
- out_data  out  DATA_WIDTH  load result or pass-through data
- out_misaligned_flag  out  1  request was misaligned and was suppressed

## Operation
- Address fields:
  - word = in_immediate[DATA_MEM_ADDR_BITS+BYTE_BITS-1:BYTE_BITS]
  - offset = in_immediate[BYTE_BITS-1:0]
  - memory row = {in_thread_index, word}
- Misaligned condition: offset is not a multiple of 2^size, with the request valid and either load or store set. On a misaligned request:
  - no memory write
  - out_write_back_flag = 0
  - out_misaligned_flag = 1
  - out_data = in_data
- Store (in_store_flag=1, aligned):
  - Byte lanes offset .. offset+2^size-1 are written with bytes 0 .. 2^size-1 of in_data.
  - All other lanes are unchanged.
  - out_write_back_flag = in_increment_flag.
  - If in_load_flag and in_store_flag are both set, the store wins and the load is ignored.
- Load (aligned):
  - Read the full row, shift right by offset*8, keep the low 2^size bytes.
  - Extend per in_signed_flag.
  - out_write_back_flag = 1.
- Neither load nor store: out_data = in_data, out_write_back_flag = in_increment_flag.
- in_valid=0: no write; next cycle out_valid=0 and all flags 0. out_data, out_reg_index and out_thread_index hold their previous values.
- Memory contents are not reset and are uninitialised after power-up.

## Timing
- Latency is 1 cycle. A request sampled at edge N appears on the outputs after edge N and stays there until edge N+1.
- Memory read is synchronous. The request registers and the read data register update on the same edge; extension and lane selection act on the registered data, so all outputs are register-driven or one mux level from registers.
- A store is committed at the edge that samples it.
- A load of the same row in the next request cycle returns the newly stored bytes; no bypass is needed.
- Throughput is one request per cycle; there is no stall or backpressure.
- rst asserted: immediately set out_valid, out_write_back_flag, out_misaligned_flag = 0 and out_data, out_reg_index, out_thread_index = 0.
- Writes are gated by !rst, so a store coinciding with reset is dropped. An in-flight result is discarded.

## Configuration
- MEM_ACCESS_STAGE_FAULT_COUNT_EN defined:
  - Adds port out_fault_count (out, 16 bits): a saturating count of misaligned valid requests.
  - Increments on the edge that samples the request.
  - Sticks at 0xFFFF; reset value is 0.
- Not defined: the port and the counter are absent, with no other behaviour change.

## Test plan
- After reset, thread 2 stores 0x1122334455667788 (size 3) at byte address 0x10, then a size-3 load from 0x10 follows. The load returns 0x1122334455667788 with out_write_back_flag=1 and out_thread_index=2, one cycle after it is issued.
- Byte store 0xAB at address 0x13 over that row, then a signed size-0 load from 0x13 and an unsigned one. Results: 0xFFFFFFFFFFFFFFAB and 0x00000000000000AB; the row now reads 0x11223344AB667788.
- Signed size-1 load from 0x16 of the row from the previous scenario returns 0x0000000000001122. Size-2 load from 0x12 gives out_misaligned_flag=1, out_write_back_flag=0, out_data=in_data, and the fault count increments when MEM_ACCESS_STAGE_FAULT_COUNT_EN is defined.
- Thread 0 and thread 5 store 1 and 5 respectively to address 0x08; loads from each return their own value, confirming thread isolation.
- Back-to-back store to address A, then load from A, then pass-through with in_increment_flag=1 and in_data=0x42. Results in order: the new data, then 0x42 with write-back set, one per cycle.
- Assert rst while a store to 0x20 is being sampled. All outputs go to 0 immediately, and a later load from 0x20 returns the pre-reset contents.

Source files
------------

// File: rtl/mem_access_stage.sv
// Registered data-memory stage: per-thread byte-lane loads/stores, one-cycle latency.
// Optional misaligned-request counter enabled by defining MEM_ACCESS_STAGE_FAULT_COUNT_EN.
module mem_access_stage #(
  parameter int DATA_WIDTH         = 64,
  parameter int IMMEDIATE_WIDTH    = 16,
  parameter int REG_INDEX_BITS     = 5,
  parameter int THREAD_INDEX_BITS  = 3,
  parameter int DATA_MEM_ADDR_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_increment_flag,
  input  logic                         in_load_flag,
  input  logic                         in_store_flag,
  input  logic [1:0]                   in_size,
  input  logic                         in_signed_flag,
  input  logic [IMMEDIATE_WIDTH-1:0]   in_immediate,
  input  logic [THREAD_INDEX_BITS-1:0] in_thread_index,
  input  logic [REG_INDEX_BITS-1:0]    in_reg_index,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  output logic                         out_write_back_flag,
  output logic [REG_INDEX_BITS-1:0]    out_reg_index,
  output logic [THREAD_INDEX_BITS-1:0] out_thread_index,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_misaligned_flag
`ifdef MEM_ACCESS_STAGE_FAULT_COUNT_EN
  ,
  output logic [15:0]                  out_fault_count
`endif
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(NUM_BYTES);
  localparam int MAX_SIZE  = BYTE_BITS;
  localparam int ROW_BITS  = THREAD_INDEX_BITS + DATA_MEM_ADDR_BITS;
  localparam int ROWS      = 1 << ROW_BITS;

  function automatic logic [1:0] clamp_size(input logic [1:0] s);
    if (int'(s) > MAX_SIZE) return 2'(MAX_SIZE);
    return s;
  endfunction

  // Keep the low 2^s bytes and fill the rest with zeros or the sign of the top kept byte.
  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [1:0] s,
                                                         input logic sgn);
    logic [DATA_WIDTH-1:0] res;
    logic                  fill;
    int                    nb;
    nb   = 1 << s;
    fill = 1'b0;
    res  = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (b == nb - 1) fill = sgn & d[b*8+7];
    end
    for (int b = 0; b < NUM_BYTES; b++) begin
      res[b*8 +: 8] = (b < nb) ? d[b*8 +: 8] : {8{fill}};
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [ROWS];

  logic [1:0]                    w_size;
  logic [BYTE_BITS-1:0]          w_offset;
  logic [BYTE_BITS-1:0]          w_align_mask;
  logic [DATA_MEM_ADDR_BITS-1:0] w_word;
  logic [ROW_BITS-1:0]           w_row;
  logic                          w_misaligned;
  logic                          w_store;
  logic                          w_load;
  logic                          w_wb;
  logic [NUM_BYTES-1:0]          w_be;
  logic [DATA_WIDTH-1:0]         w_wdata;
  logic                          w_unused_imm;

  assign w_size       = clamp_size(in_size);
  assign w_offset     = in_immediate[BYTE_BITS-1:0];
  assign w_word       = in_immediate[DATA_MEM_ADDR_BITS+BYTE_BITS-1:BYTE_BITS];
  assign w_row        = {in_thread_index, w_word};
  assign w_unused_imm = ^in_immediate;

  always_comb begin
    w_align_mask = '0;
    for (int i = 0; i < BYTE_BITS; i++) w_align_mask[i] = (i < int'(w_size));
  end

  assign w_misaligned = in_valid && (in_load_flag || in_store_flag) &&
                        ((w_offset & w_align_mask) != '0);
  assign w_store = in_valid && in_store_flag && !w_misaligned && !rst;
  assign w_load  = in_load_flag && !in_store_flag && !w_misaligned;

  always_comb begin
    if (w_misaligned)       w_wb = 1'b0;
    else if (in_store_flag) w_wb = in_increment_flag;
    else if (in_load_flag)  w_wb = 1'b1;
    else                    w_wb = in_increment_flag;
  end

  always_comb begin
    w_be    = '0;
    w_wdata = in_data << {w_offset, 3'b000};
    for (int b = 0; b < NUM_BYTES; b++) begin
      w_be[b] = (b >= int'(w_offset)) && (b < int'(w_offset) + (1 << w_size));
    end
  end

  // ---- stage p0 -> p1: memory write commit and synchronous row read
  logic [DATA_WIDTH-1:0] r_rd_data_p1;

  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (w_be[b]) r_mem[w_row][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
    if (in_valid && !rst) r_rd_data_p1 <= r_mem[w_row];
  end

  // Request fields only advance on valid so the outputs hold across bubbles.
  logic                         r_vld_p1;
  logic                         r_wb_p1;
  logic                         r_mis_p1;
  logic                         r_is_load_p1;
  logic [1:0]                   r_size_p1;
  logic                         r_signed_p1;
  logic [BYTE_BITS-1:0]         r_offset_p1;
  logic [DATA_WIDTH-1:0]        r_data_p1;
  logic [REG_INDEX_BITS-1:0]    r_reg_p1;
  logic [THREAD_INDEX_BITS-1:0] r_thread_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_wb_p1      <= 1'b0;
      r_mis_p1     <= 1'b0;
      r_is_load_p1 <= 1'b0;
      r_size_p1    <= '0;
      r_signed_p1  <= 1'b0;
      r_offset_p1  <= '0;
      r_data_p1    <= '0;
      r_reg_p1     <= '0;
      r_thread_p1  <= '0;
    end else begin
      r_vld_p1 <= in_valid;
      r_wb_p1  <= in_valid && w_wb;
      r_mis_p1 <= w_misaligned;
      if (in_valid) begin
        r_is_load_p1 <= w_load;
        r_size_p1    <= w_size;
        r_signed_p1  <= in_signed_flag;
        r_offset_p1  <= w_offset;
        r_data_p1    <= in_data;
        r_reg_p1     <= in_reg_index;
        r_thread_p1  <= in_thread_index;
      end
    end
  end

  // ---- stage p1 outputs: lane select and extension on registered row
  logic [DATA_WIDTH-1:0] w_shifted;
  assign w_shifted = r_rd_data_p1 >> {r_offset_p1, 3'b000};

  assign out_valid           = r_vld_p1;
  assign out_write_back_flag = r_wb_p1;
  assign out_misaligned_flag = r_mis_p1;
  assign out_reg_index       = r_reg_p1;
  assign out_thread_index    = r_thread_p1;
  assign out_data            = r_is_load_p1 ? extend_load(w_shifted, r_size_p1, r_signed_p1)
                                            : r_data_p1;

`ifdef MEM_ACCESS_STAGE_FAULT_COUNT_EN
  logic [15:0] r_fault_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_fault_cnt <= '0;
    else if (w_misaligned && r_fault_cnt != 16'hFFFF) r_fault_cnt <= r_fault_cnt + 16'd1;
  end

  assign out_fault_count = r_fault_cnt;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores, loads, extension, misalignment, threads, reset.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_increment_flag;
  logic        in_load_flag;
  logic        in_store_flag;
  logic [1:0]  in_size;
  logic        in_signed_flag;
  logic [15:0] in_immediate;
  logic [2:0]  in_thread_index;
  logic [4:0]  in_reg_index;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_write_back_flag;
  logic [4:0]  out_reg_index;
  logic [2:0]  out_thread_index;
  logic [63:0] out_data;
  logic        out_misaligned_flag;
`ifdef MEM_ACCESS_STAGE_FAULT_COUNT_EN
  logic [15:0] out_fault_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  mem_access_stage dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_increment_flag  (in_increment_flag),
    .in_load_flag       (in_load_flag),
    .in_store_flag      (in_store_flag),
    .in_size            (in_size),
    .in_signed_flag     (in_signed_flag),
    .in_immediate       (in_immediate),
    .in_thread_index    (in_thread_index),
    .in_reg_index       (in_reg_index),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_write_back_flag(out_write_back_flag),
    .out_reg_index      (out_reg_index),
    .out_thread_index   (out_thread_index),
    .out_data           (out_data),
    .out_misaligned_flag(out_misaligned_flag)
`ifdef MEM_ACCESS_STAGE_FAULT_COUNT_EN
    ,
    .out_fault_count    (out_fault_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input logic v, input logic inc, input logic ld, input logic st,
                         input logic [1:0] sz, input logic sg, input logic [15:0] imm,
                         input logic [2:0] thr, input logic [4:0] ri, input logic [63:0] d);
    in_valid = v; in_increment_flag = inc; in_load_flag = ld; in_store_flag = st;
    in_size = sz; in_signed_flag = sg; in_immediate = imm;
    in_thread_index = thr; in_reg_index = ri; in_data = d;
  endtask

  task automatic issue(input logic v, input logic inc, input logic ld, input logic st,
                       input logic [1:0] sz, input logic sg, input logic [15:0] imm,
                       input logic [2:0] thr, input logic [4:0] ri, input logic [63:0] d);
    set_req(v, inc, ld, st, sz, sg, imm, thr, ri, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_req(0, 0, 0, 0, 2'd0, 0, 16'h0, 3'd0, 5'd0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (out_write_back_flag !== 1'b0) begin n_err++; $display("FAIL reset_wb: got %b want 0", out_write_back_flag); end
    n_vec++; if (out_misaligned_flag !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b want 0", out_misaligned_flag); end
    n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
`ifdef MEM_ACCESS_STAGE_FAULT_COUNT_EN
    n_vec++; if (out_fault_count !== 16'h0) begin n_err++; $display("FAIL reset_fcnt: got %h want 0", out_fault_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_store_load;
    issue(1, 0, 0, 1, 2'd3, 0, 16'h0010, 3'd2, 5'd1, 64'h1122334455667788);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL st_valid: got %b want 1", out_valid); end
    n_vec++; if (out_write_back_flag !== 1'b0) begin n_err++; $display("FAIL st_wb: got %b want 0", out_write_back_flag); end
    n_vec++; if (out_misaligned_flag !== 1'b0) begin n_err++; $display("FAIL st_mis: got %b want 0", out_misaligned_flag); end
    issue(1, 0, 1, 0, 2'd3, 0, 16'h0010, 3'd2, 5'd7, 64'h0);
    n_vec++; if (out_data !== 64'h1122334455667788) begin n_err++; $display("FAIL ld_data: got %h want 1122334455667788", out_data); end
    n_vec++; if (out_write_back_flag !== 1'b1) begin n_err++; $display("FAIL ld_wb: got %b want 1", out_write_back_flag); end
    n_vec++; if (out_thread_index !== 3'd2) begin n_err++; $display("FAIL ld_thread: got %0d want 2", out_thread_index); end
    n_vec++; if (out_reg_index !== 5'd7) begin n_err++; $display("FAIL ld_reg: got %0d want 7", out_reg_index); end
  endtask

  task automatic test_byte_extend;
    issue(1, 0, 0, 1, 2'd0, 0, 16'h0013, 3'd2, 5'd1, 64'h00000000000000AB);
    issue(1, 0, 1, 0, 2'd0, 1, 16'h0013, 3'd2, 5'd3, 64'h0);
    n_vec++; if (out_data !== 64'hFFFFFFFFFFFFFFAB) begin n_err++; $display("FAIL ldb_signed: got %h want ffffffffffffffab", out_data); end
    issue(1, 0, 1, 0, 2'd0, 0, 16'h0013, 3'd2, 5'd3, 64'h0);
    n_vec++; if (out_data !== 64'h00000000000000AB) begin n_err++; $display("FAIL ldb_unsigned: got %h want 00000000000000ab", out_data); end
    issue(1, 0, 1, 0, 2'd3, 0, 16'h0010, 3'd2, 5'd3, 64'h0);
    n_vec++; if (out_data !== 64'h11223344AB667788) begin n_err++; $display("FAIL row_after_byte: got %h want 11223344ab667788", out_data); end
  endtask

  task automatic test_half_misaligned;
    issue(1, 0, 1, 0, 2'd1, 1, 16'h0016, 3'd2, 5'd4, 64'h0);
    n_vec++; if (out_data !== 64'h0000000000001122) begin n_err++; $display("FAIL ldh_signed: got %h want 0000000000001122", out_data); end
    issue(1, 1, 1, 0, 2'd2, 0, 16'h0012, 3'd2, 5'd9, 64'h000000000000DEAD);
    n_vec++; if (out_misaligned_flag !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b want 1", out_misaligned_flag); end
    n_vec++; if (out_write_back_flag !== 1'b0) begin n_err++; $display("FAIL mis_wb: got %b want 0", out_write_back_flag); end
    n_vec++; if (out_data !== 64'h000000000000DEAD) begin n_err++; $display("FAIL mis_data: got %h want dead", out_data); end
`ifdef MEM_ACCESS_STAGE_FAULT_COUNT_EN
    n_vec++; if (out_fault_count !== 16'd1) begin n_err++; $display("FAIL mis_fcnt: got %0d want 1", out_fault_count); end
`endif
    // bubble: flags clear, data/reg/thread hold
    issue(0, 1, 1, 1, 2'd3, 0, 16'h0000, 3'd6, 5'd30, 64'h5555);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bub_valid: got %b want 0", out_valid); end
    n_vec++; if (out_misaligned_flag !== 1'b0) begin n_err++; $display("FAIL bub_mis: got %b want 0", out_misaligned_flag); end
    n_vec++; if (out_data !== 64'h000000000000DEAD) begin n_err++; $display("FAIL bub_data: got %h want dead", out_data); end
    n_vec++; if (out_reg_index !== 5'd9) begin n_err++; $display("FAIL bub_reg: got %0d want 9", out_reg_index); end
    // misaligned store must not touch memory
    issue(1, 0, 0, 1, 2'd1, 0, 16'h0011, 3'd2, 5'd0, 64'hFFFF);
    n_vec++; if (out_misaligned_flag !== 1'b1) begin n_err++; $display("FAIL misst_flag: got %b want 1", out_misaligned_flag); end
`ifdef MEM_ACCESS_STAGE_FAULT_COUNT_EN
    n_vec++; if (out_fault_count !== 16'd2) begin n_err++; $display("FAIL misst_fcnt: got %0d want 2", out_fault_count); end
`endif
    issue(1, 0, 1, 0, 2'd3, 0, 16'h0010, 3'd2, 5'd3, 64'h0);
    n_vec++; if (out_data !== 64'h11223344AB667788) begin n_err++; $display("FAIL misst_row: got %h want 11223344ab667788", out_data); end
  endtask

  task automatic test_threads;
    issue(1, 0, 0, 1, 2'd3, 0, 16'h0008, 3'd0, 5'd0, 64'd1);
    issue(1, 0, 0, 1, 2'd3, 0, 16'h0008, 3'd5, 5'd0, 64'd5);
    issue(1, 0, 1, 0, 2'd3, 0, 16'h0008, 3'd0, 5'd2, 64'h0);
    n_vec++; if (out_data !== 64'd1) begin n_err++; $display("FAIL thr0_data: got %h want 1", out_data); end
    issue(1, 0, 1, 0, 2'd3, 0, 16'h0008, 3'd5, 5'd2, 64'h0);
    n_vec++; if (out_data !== 64'd5) begin n_err++; $display("FAIL thr5_data: got %h want 5", out_data); end
    n_vec++; if (out_thread_index !== 3'd5) begin n_err++; $display("FAIL thr5_idx: got %0d want 5", out_thread_index); end
  endtask

  task automatic test_back_to_back;
    issue(1, 0, 0, 1, 2'd3, 0, 16'h0030, 3'd1, 5'd0, 64'hCAFEBABE12345678);
    issue(1, 0, 1, 0, 2'd3, 0, 16'h0030, 3'd1, 5'd11, 64'h0);
    n_vec++; if (out_data !== 64'hCAFEBABE12345678) begin n_err++; $display("FAIL b2b_ld: got %h want cafebabe12345678", out_data); end
    issue(1, 1, 0, 0, 2'd0, 0, 16'h0000, 3'd1, 5'd12, 64'h42);
    n_vec++; if (out_data !== 64'h42) begin n_err++; $display("FAIL b2b_pass: got %h want 42", out_data); end
    n_vec++; if (out_write_back_flag !== 1'b1) begin n_err++; $display("FAIL b2b_pass_wb: got %b want 1", out_write_back_flag); end
    // load+store together: store wins
    issue(1, 0, 1, 1, 2'd3, 0, 16'h0038, 3'd1, 5'd0, 64'h0BADF00D0BADF00D);
    n_vec++; if (out_write_back_flag !== 1'b0) begin n_err++; $display("FAIL ldst_wb: got %b want 0", out_write_back_flag); end
    issue(1, 0, 1, 0, 2'd3, 0, 16'h0038, 3'd1, 5'd0, 64'h0);
    n_vec++; if (out_data !== 64'h0BADF00D0BADF00D) begin n_err++; $display("FAIL ldst_data: got %h want 0badf00d0badf00d", out_data); end
  endtask

  task automatic test_reset_during_store;
    issue(1, 0, 0, 1, 2'd3, 0, 16'h0020, 3'd3, 5'd6, 64'h0123456789ABCDEF);
    set_req(1, 1, 0, 1, 2'd3, 0, 16'h0020, 3'd3, 5'd6, 64'hFFFFFFFFFFFFFFFF);
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", out_data); end
    n_vec++; if (out_reg_index !== 5'd0) begin n_err++; $display("FAIL rst_reg: got %0d want 0", out_reg_index); end
    n_vec++; if (out_thread_index !== 3'd0) begin n_err++; $display("FAIL rst_thread: got %0d want 0", out_thread_index); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1, 0, 1, 0, 2'd3, 0, 16'h0020, 3'd3, 5'd6, 64'h0);
    n_vec++; if (out_data !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL rst_dropped_store: got %h want 0123456789abcdef", out_data); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_extend();
    test_half_misaligned();
    test_threads();
    test_back_to_back();
    test_reset_during_store();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
